// File: rtl/a2d_rr_intf.sv
// a2d_rr_intf: ADC128S SPI master servicing channels 0,4,5 in round-robin order; optional macro A2D_AVG_EN averages each new result with the old one.
// Latency: nxt (sampled in IDLE) to cnv_cmplt is 1046 clk: two 521-clk SPI frames, a 2-clk SS_n gap and one DONE clk.
// Backpressure: nxt is honoured only in IDLE; requests arriving while busy are dropped, not queued.
module a2d_rr_intf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        cnv_cmplt
);
    typedef enum logic [2:0] {IDLE, CMD, GAP, READ, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  sclk_div;
    logic [4:0]  smpl_cnt;
    logic [15:0] tx_shft;
    logic [11:0] rx_shft;
    logic        gap_cnt;
    logic [1:0]  ch_ptr;
    logic [2:0]  ch;
    logic [15:0] cmd;
    logic        smpl;
    logic        shft;
    logic        txn_end;
    logic        ld_txn;
    logic        wr_res;
    logic [11:0] new_val;

    always_comb begin
        case (ch_ptr)
            2'd1:    ch = 3'd4;
            2'd2:    ch = 3'd5;
            default: ch = 3'd0;
        endcase
    end

    assign cmd  = {2'b00, ch, 11'h000};
    assign SCLK = sclk_div[4];
    assign MOSI = tx_shft[15];

    assign smpl    = !SS_n && (sclk_div == 5'b01111);
    assign txn_end = !SS_n && (sclk_div == 5'b11111) && (smpl_cnt == 5'd16);
    // The first SCLK fall only opens the frame, so bit 15 is still on MOSI at the first rise.
    assign shft    = !SS_n && (sclk_div == 5'b11111) &&
                     (smpl_cnt != 5'd0) && (smpl_cnt != 5'd16);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld_txn    = 1'b0;
        wr_res    = 1'b0;
        case (state)
            IDLE: begin
                if (nxt) begin
                    ld_txn    = 1'b1;
                    state_nxt = CMD;
                end
            end
            CMD: begin
                if (txn_end) state_nxt = GAP;
            end
            GAP: begin
                if (gap_cnt) begin
                    ld_txn    = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                if (txn_end) state_nxt = DONE;
            end
            DONE: begin
                wr_res    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // SPI datapath; the divider holds at 31 after the last rise so SCLK idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SS_n     <= 1'b1;
            sclk_div <= 5'b10111;
            smpl_cnt <= 5'd0;
            tx_shft  <= 16'h0000;
            rx_shft  <= 12'h000;
            gap_cnt  <= 1'b0;
        end else begin
            gap_cnt <= (state == GAP);
            if (ld_txn) begin
                SS_n     <= 1'b0;
                sclk_div <= 5'b10111;
                smpl_cnt <= 5'd0;
                tx_shft  <= cmd;
            end else begin
                if (txn_end) begin
                    SS_n <= 1'b1;
                end else if (!SS_n) begin
                    sclk_div <= sclk_div + 5'd1;
                end
                if (smpl) smpl_cnt <= smpl_cnt + 5'd1;
                if (shft) tx_shft <= {tx_shft[14:0], 1'b0};
            end
            if (smpl) rx_shft <= {rx_shft[10:0], MISO};
        end
    end

`ifdef A2D_AVG_EN
    logic [11:0] old_val;
    logic [12:0] sum;

    always_comb begin
        case (ch_ptr)
            2'd1:    old_val = rght_ld;
            2'd2:    old_val = batt;
            default: old_val = lft_ld;
        endcase
    end

    assign sum     = {1'b0, old_val} + {1'b0, rx_shft};
    assign new_val = 12'(sum >> 1);
`else
    assign new_val = rx_shft;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            batt      <= 12'h000;
            cnv_cmplt <= 1'b0;
            ch_ptr    <= 2'd0;
        end else begin
            cnv_cmplt <= wr_res;
            if (wr_res) begin
                case (ch_ptr)
                    2'd0:    lft_ld  <= new_val;
                    2'd1:    rght_ld <= new_val;
                    2'd2:    batt    <= new_val;
                    default: ;
                endcase
                ch_ptr <= (ch_ptr >= 2'd2) ? 2'd0 : ch_ptr + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_a2d_rr_intf.sv
// Directed bench for a2d_rr_intf with a behavioural ADC128S: the READ frame returns the value of the
// channel named by the previous command, with a junk upper nibble.
module tb_a2d_rr_intf;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        nxt;
    logic        MISO;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        cnv_cmplt;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] batt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cmplt_cnt = 0;
    int lat   = 0;

    logic [11:0] ch_val [8];
    logic [15:0] mosi_word = 16'h0;
    logic [15:0] miso_word = 16'h0;
    logic [15:0] prev_cmd  = 16'h0;
    logic [15:0] cmd_q [$];
    int rise_cnt = 0, ss_fall_cyc = 0, ss_rise_cyc = 0, ss_low_len = 0, gap_len = 0;
    int first_fall_dly = 0, per_bad = 0, last_rise_cyc = 0, rises_last = 0;
    logic [11:0] exp_l = 12'h0, exp_r = 12'h0, exp_b = 12'h0;

    a2d_rr_intf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nxt       (nxt),
        .MISO      (MISO),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .batt      (batt),
        .cnv_cmplt (cnv_cmplt)
    );

    always #5 clk = ~clk;
    always @(negedge clk) cyc = cyc + 1;
    always @(posedge clk) if (cnv_cmplt === 1'b1) cmplt_cnt = cmplt_cnt + 1;

    // ADC128S model: DOUT changes on SCLK falls (after the opening fall), DIN sampled on rises.
    always @(negedge SS_n) begin
        gap_len        = cyc - ss_rise_cyc;
        ss_fall_cyc    = cyc;
        rise_cnt       = 0;
        mosi_word      = 16'h0;
        first_fall_dly = -1;
        miso_word      = {4'hA, ch_val[prev_cmd[13:11]]};
        MISO           = miso_word[15];
    end

    always @(negedge SCLK) begin
        if (SS_n === 1'b0 && rst_n === 1'b1) begin
            if (rise_cnt == 0) begin
                first_fall_dly = cyc - ss_fall_cyc;
            end else begin
                miso_word = {miso_word[14:0], 1'b0};
                MISO      = miso_word[15];
            end
        end
    end

    always @(posedge SCLK) begin
        if (SS_n === 1'b0 && rst_n === 1'b1) begin
            if (rise_cnt > 0 && (cyc - last_rise_cyc) != 32) per_bad = per_bad + 1;
            last_rise_cyc = cyc;
            mosi_word     = {mosi_word[14:0], MOSI};
            rise_cnt      = rise_cnt + 1;
        end
    end

    always @(posedge SS_n) begin
        ss_rise_cyc = cyc;
        ss_low_len  = cyc - ss_fall_cyc;
        rises_last  = rise_cnt;
        if (rise_cnt == 16) begin
            cmd_q.push_back(mosi_word);
            prev_cmd = mosi_word;
        end
    end

    function automatic logic [11:0] upd(input logic [11:0] old_v, input logic [11:0] new_v);
        logic [12:0] s;
        s = {1'b0, old_v} + {1'b0, new_v};
`ifdef A2D_AVG_EN
        return s[12:1];
`else
        return (s[0] === 1'bx) ? 12'hx : new_v;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_cmd(input string tag, input logic [15:0] exp);
        if (cmd_q.size() == 0) check(tag, 32'hFFFF_FFFF, {16'h0, exp});
        else                   check(tag, {16'h0, cmd_q.pop_front()}, {16'h0, exp});
    endtask

    task automatic pulse_nxt();
        @(negedge clk) nxt = 1'b1;
        @(posedge clk);
        #1 nxt = 1'b0;
    endtask

    // Entered #1 after the edge that accepted nxt; that edge counts as clk 1.
    task automatic wait_done(input string tag);
        lat = 1;
        while (cnv_cmplt !== 1'b1 && lat < 3000) begin
            @(posedge clk);
            #1 lat = lat + 1;
        end
        check({tag, "_lat"}, lat, 1046);
        check({tag, "_ss_low"}, ss_low_len, 521);
        check({tag, "_gap"}, gap_len, 2);
        check({tag, "_rises"}, rises_last, 16);
        check({tag, "_first_fall"}, first_fall_dly, 9);
        check({tag, "_period"}, per_bad, 0);
        @(posedge clk);
        #1 check({tag, "_pulse"}, cnv_cmplt, 0);
    endtask

    initial begin
        rst_n = 1'b1;
        nxt   = 1'b0;
        MISO  = 1'b0;
        for (int i = 0; i < 8; i++) ch_val[i] = 12'h000;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss", SS_n, 1);
        check("rst_sclk", SCLK, 1);
        check("rst_mosi", MOSI, 0);
        check("rst_cmplt", cnv_cmplt, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("idle_ss", SS_n, 1);
        check("idle_sclk", SCLK, 1);
        check("idle_mosi", MOSI, 0);
        check("idle_lft", lft_ld, 0);
        check("idle_rght", rght_ld, 0);
        check("idle_batt", batt, 0);
        check("idle_no_cmplt", cmplt_cnt, 0);

        ch_val[0] = 12'h001;
        pulse_nxt();
        wait_done("c1");
        chk_cmd("c1_cmd", 16'h0000);
        chk_cmd("c1_rd", 16'h0000);
        exp_l = upd(exp_l, 12'h001);
        check("c1_lft", lft_ld, exp_l);
        check("c1_rght", rght_ld, 0);

        ch_val[4] = 12'h030;
        pulse_nxt();
        wait_done("c2");
        chk_cmd("c2_cmd", 16'h2000);
        chk_cmd("c2_rd", 16'h2000);
        exp_r = upd(exp_r, 12'h030);
        check("c2_rght", rght_ld, exp_r);

        ch_val[5] = 12'hFFF;
        pulse_nxt();
        wait_done("c3");
        chk_cmd("c3_cmd", 16'h2800);
        chk_cmd("c3_rd", 16'h2800);
        exp_b = upd(exp_b, 12'hFFF);
        check("c3_batt", batt, exp_b);

        ch_val[0] = 12'h003;
        pulse_nxt();
        wait_done("c4");
        chk_cmd("c4_cmd", 16'h0000);
        chk_cmd("c4_rd", 16'h0000);
        exp_l = upd(exp_l, 12'h003);
        check("c4_lft", lft_ld, exp_l);
        check("c4_rght_hold", rght_ld, exp_r);
        check("c4_batt_hold", batt, exp_b);

        // nxt held high: the second conversion starts on the clk after cnv_cmplt.
        ch_val[4] = 12'h123;
        ch_val[5] = 12'h456;
        @(negedge clk) nxt = 1'b1;
        @(posedge clk);
        #1;
        wait_done("b2b1");
        check("b2b_restart", SS_n, 0);
        nxt = 1'b0;
        exp_r = upd(exp_r, 12'h123);
        check("b2b1_rght", rght_ld, exp_r);
        wait_done("b2b2");
        exp_b = upd(exp_b, 12'h456);
        check("b2b2_batt", batt, exp_b);
        chk_cmd("b2b_w0", 16'h2000);
        chk_cmd("b2b_w1", 16'h2000);
        chk_cmd("b2b_w2", 16'h2800);
        chk_cmd("b2b_w3", 16'h2800);

        ch_val[0] = 12'h0AB;
        pulse_nxt();
        wait_done("c5");
        chk_cmd("c5_cmd", 16'h0000);
        chk_cmd("c5_rd", 16'h0000);
        exp_l = upd(exp_l, 12'h0AB);
        check("c5_lft", lft_ld, exp_l);

        // Reset at clk 300 of a ch4 READ frame.
        pulse_nxt();
        repeat (523 + 300) @(posedge clk);
        #1;
        check("pre_rst_ss", SS_n, 0);
        check("pre_rst_sclk", SCLK, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ss", SS_n, 1);
        check("arst_sclk", SCLK, 1);
        check("arst_lft", lft_ld, 0);
        check("arst_rght", rght_ld, 0);
        check("arst_batt", batt, 0);
        check("arst_cmplt", cnv_cmplt, 0);
        exp_l = 12'h000;
        exp_r = 12'h000;
        exp_b = 12'h000;
        @(negedge clk) rst_n = 1'b1;
        chk_cmd("abort_cmd", 16'h2000);

        ch_val[0] = 12'h777;
        pulse_nxt();
        wait_done("c7");
        chk_cmd("c7_cmd", 16'h0000);
        chk_cmd("c7_rd", 16'h0000);
        exp_l = upd(exp_l, 12'h777);
        check("c7_lft", lft_ld, exp_l);
        check("c7_rght", rght_ld, 0);
        check("q_empty", cmd_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/a2d_rr_intf.md
# a2d_rr_intf

SPI master that drives the ADC128S 12-bit A2D converter on the Segway board and services channels 0 (left load cell), 4 (right load cell) and 5 (battery) in fixed round-robin order. Each `nxt` request performs one conversion, two 16-bit SPI transactions, on the next channel in rotation and updates that channel's holding register. It sits between the ADC128S pins and the balance/steering logic, which consumes `lft_ld`, `rght_ld` and `batt`.

## Interface
- No parameters; SCLK divide ratio (32) and channel set {0,4,5} are fixed.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `nxt` in 1: start a conversion on the next channel; honoured only when idle.
- `MISO` in 1: serial data from ADC.
- `SS_n` out 1: active-low slave select; reset 1.
- `SCLK` out 1: serial clock, clk/32, idles high; reset 1.
- `MOSI` out 1: serial data to ADC; reset 0.
- `lft_ld` out 12: last channel-0 result; reset 12'h000.
- `rght_ld` out 12: last channel-4 result; reset 12'h000.
- `batt` out 12: last channel-5 result; reset 12'h000.
- `cnv_cmplt` out 1: one-clk pulse when a holding register updates; reset 0.

## Operation
- Channel pointer rotates 0 -> 4 -> 5 -> 0. Resets to 0 and advances only on `cnv_cmplt`.
- Command word is {2'b00, ch[2:0], 11'h000}, sent MSB first.
- States:
  - IDLE: `nxt` -> CMD; otherwise stay.
  - CMD: transmit the command word and discard received bits; on transaction end -> GAP.
  - GAP: `SS_n` high for exactly 2 clk -> READ.
  - READ: transmit the same command word and capture 16 bits; on end -> DONE.
  - DONE: one clk; write rx[11:0] to the selected register, pulse `cnv_cmplt`, advance the pointer -> IDLE.
- `nxt` outside IDLE is ignored; requests are not queued.
- rx[15:12] are discarded.
- Reset mid-transaction: `SS_n` = 1 and `SCLK` = 1 immediately (async); state IDLE; pointer 0; outputs cleared.

## Timing
- 5-bit divider `sclk_div`; `SCLK` = `sclk_div[4]`. The divider loads 5'b10111 in the clk where `SS_n` falls and increments every clk while `SS_n` = 0.
- First SCLK fall is 9 clk after `SS_n` falls. Each rise follows the preceding fall by 16 clk; period is 32 clk.
- MOSI:
  - Bit 15 is driven when `SS_n` falls.
  - Shift on the clk where `sclk_div` == 5'b11111, so MOSI changes with the SCLK fall.
- MISO is sampled on the clk where `sclk_div` == 5'b01111, i.e. the edge at which SCLK rises. 16 samples are taken per transaction.
- `SS_n` rises 16 clk after the 16th rise, with SCLK high. `SS_n` is low for 521 clk per transaction.
- Conversion latency from `nxt` (sampled in IDLE) to `cnv_cmplt` = 1 + 521 + 2 + 521 + 1 = 1046 clk.
- A new `nxt` is accepted in the clk after `cnv_cmplt`.
- Holding registers change only in DONE and are stable otherwise.

## Configuration
- Macro `A2D_AVG_EN`.
- Defined: DONE writes (old + new) >> 1 into the selected register. The sum is 13-bit with no overflow, truncated toward zero. The first conversion after reset averages with 0.
- Undefined: DONE writes rx[11:0] directly. No adder is present.

## Test plan
- Reset, no `nxt` for 100 clk -> `SS_n` = 1, `SCLK` = 1, `MOSI` = 0, all outputs 12'h000, `cnv_cmplt` never pulses.
- Single `nxt` against the ADC128S bench model -> MOSI words 16'h0000 then 16'h0000; `cnv_cmplt` pulses 1046 clk after `nxt`; `lft_ld` = 12'h001.
- Three more `nxt`, each after the prior `cnv_cmplt` -> command words 16'h2000 (ch4) and 16'h2800 (ch5); `rght_ld` = 12'h030, `batt` = 12'hFFF; the fourth `nxt` wraps to ch0 and gives `lft_ld` = 12'h003.
- `nxt` held high continuously -> conversions back-to-back with 1 IDLE clk between; per transaction exactly 16 SCLK rises, 32-clk period, `SS_n` low 521 clk, 2-clk gap between CMD and READ.
- `rst_n` asserted at clk 300 of a READ -> `SS_n` and `SCLK` go high asynchronously, outputs 0; after release, the next `nxt` targets ch0.
- With `A2D_AVG_EN`, two ch0 conversions returning 12'h001 then 12'h003 -> `lft_ld` = 12'h000, then 12'h001.
